// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and instruction-class type for the MIPS execute slice.
// Used by mips_decoder and mips_exec_unit (optional shifter enabled by ALU_SHIFT_EN).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b111111;
  localparam logic [5:0] OP_JR    = 6'b111110;
  localparam logic [5:0] OP_JAL   = 6'b111101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_BGT   = 6'b000111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_J
  } instr_class_e;

  function automatic instr_class_e class_of(input logic [5:0] opcode);
    instr_class_e cls;
    cls = CLS_NONE;
    case (opcode)
      OP_RTYPE:                      cls = CLS_R;
      OP_J, OP_JR, OP_JAL:           cls = CLS_J;
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_BLE, OP_BGT: cls = CLS_I;
      default:                       cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_decoder.sv
// Instruction-class decoder: one-hot (or all-low) R/I/J flags from the opcode field.
// Configuration macro ALU_SHIFT_EN does not affect this block.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_r,
  output logic        is_i,
  output logic        is_j
);

  instr_class_e w_cls;
  logic         w_unused_fields;

  assign w_cls           = class_of(instr[31:26]);
  assign w_unused_fields = ^instr[25:0];

  // Derived from a single enum value, so at most one flag can be high.
  assign is_r = (w_cls == CLS_R);
  assign is_i = (w_cls == CLS_I);
  assign is_j = (w_cls == CLS_J);

endmodule

// File: rtl/mips_exec_unit.sv
// Single-cycle MIPS execute stage: class decode, ALU, branch decision, registered copies.
// Define ALU_SHIFT_EN to enable the R-type sll/srl shifter.
module mips_exec_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              is_r,
  output logic              is_i,
  output logic              is_j,
  output logic [DATA_W-1:0] result,
  output logic              branch,
  output logic              zero,
  output logic [DATA_W-1:0] result_q,
  output logic              branch_q
);

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_result;
  logic              w_branch;
  logic              w_unused_fields;
  logic [DATA_W-1:0] r_result_q;
  logic              r_branch_q;

  assign w_opcode        = instr[31:26];
  assign w_funct         = instr[5:0];
  assign w_shamt         = instr[10:6];
  assign w_unused_fields = ^{instr[25:11], w_shamt};

  mips_decoder u_decoder (
    .instr (instr),
    .is_r  (is_r),
    .is_i  (is_i),
    .is_j  (is_j)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_result = '0;
    w_branch = 1'b0;
    if (is_r) begin
      case (w_funct)
        FN_ADD:  w_result = op_a + op_b;
        FN_SUB:  w_result = op_a - op_b;
        FN_AND:  w_result = op_a & op_b;
        FN_OR:   w_result = op_a | op_b;
        FN_XOR:  w_result = op_a ^ op_b;
        FN_NOR:  w_result = ~(op_a | op_b);
        FN_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_SHIFT_EN
        FN_SLL:  w_result = op_b << w_shamt;
        FN_SRL:  w_result = op_b >> w_shamt;
`endif
        default: w_result = '0;
      endcase
    end else if (is_i) begin
      case (w_opcode)
        OP_ADDI, OP_LW, OP_SW: w_result = op_a + op_b;
        OP_ANDI:               w_result = op_a & op_b;
        OP_ORI:                w_result = op_a | op_b;
        OP_BEQ: begin
          w_result = op_a - op_b;
          w_branch = (op_a == op_b);
        end
        OP_BNE: begin
          w_result = op_a - op_b;
          w_branch = (op_a != op_b);
        end
        OP_BLE: begin
          w_result = op_a - op_b;
          w_branch = ($signed(op_a) <= $signed(op_b));
        end
        OP_BGT: begin
          w_result = op_a - op_b;
          w_branch = ($signed(op_a) > $signed(op_b));
        end
        default: w_result = '0;
      endcase
    end
  end

  assign result = w_result;
  assign branch = w_branch;
  assign zero   = (w_result == '0);

  // Reset clears only the registered copies; the combinational path ignores rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep register updates order-independent.
    if (!rst_n) begin
      r_result_q <= '0;
      r_branch_q <= 1'b0;
    end else begin
      r_result_q <= w_result;
      r_branch_q <= w_branch;
    end
  end

  assign result_q = r_result_q;
  assign branch_q = r_branch_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed vector table, reset sequence, random vs model.
// Build with ALU_SHIFT_EN defined to check the shifter variant.
module tb_mips_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_r, is_i, is_j;
  logic [31:0] result;
  logic        branch;
  logic        zero;
  logic [31:0] result_q;
  logic        branch_q;

  int n_checks = 0;
  int n_errors = 0;

  mips_exec_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .op_a     (op_a),
    .op_b     (op_b),
    .is_r     (is_r),
    .is_i     (is_i),
    .is_j     (is_j),
    .result   (result),
    .branch   (branch),
    .zero     (zero),
    .result_q (result_q),
    .branch_q (branch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic [2:0]  cls;   // {is_r, is_i, is_j}
  } vec_t;

  localparam logic [2:0] C_R = 3'b100, C_I = 3'b010, C_J = 3'b001, C_N = 3'b000;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] shamt,
                                     input logic [5:0] funct);
    return {op, 5'd1, 5'd2, 5'd3, shamt, funct};
  endfunction

  function automatic vec_t v(input string name, input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res, input logic br,
                             input logic [2:0] cls);
    vec_t t;
    t.name = name; t.instr = ins; t.a = a; t.b = b; t.res = res; t.br = br; t.cls = cls;
    return t;
  endfunction

  // Reference model: instruction semantics by mnemonic, straight arithmetic.
  task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic br, output logic [2:0] cls);
    logic [5:0] op;
    logic [5:0] fn;
    int         sh;
    op  = ins[31:26];
    fn  = ins[5:0];
    sh  = int'(ins[10:6]);
    res = 32'd0;
    br  = 1'b0;
    cls = C_N;
    if (op == 6'h00) begin
      cls = C_R;
      case (fn)
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: res = SHIFT_ON ? 32'(64'(b) * (64'd1 << sh)) : 32'd0;
        6'h02: res = SHIFT_ON ? 32'(b / (33'd1 << sh)) : 32'd0;
        default: res = 32'd0;
      endcase
    end else if (op == 6'h3F || op == 6'h3E || op == 6'h3D) begin
      cls = C_J;
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      cls = C_I; res = a + b;
    end else if (op == 6'h0C) begin
      cls = C_I; res = a & b;
    end else if (op == 6'h0D) begin
      cls = C_I; res = a | b;
    end else if (op >= 6'h04 && op <= 6'h07) begin
      cls = C_I;
      res = a - b;
      case (op)
        6'h04: br = (a == b);
        6'h05: br = (a != b);
        6'h06: br = ($signed(a) <= $signed(b));
        default: br = ($signed(a) > $signed(b));
      endcase
    end
  endtask

  task automatic apply_and_check(input vec_t t);
    @(negedge clk);
    instr = t.instr;
    op_a  = t.a;
    op_b  = t.b;
    #1;
    check({t.name, " result"}, result, t.res);
    check({t.name, " branch"}, 32'(branch), 32'(t.br));
    check({t.name, " class"}, 32'({is_r, is_i, is_j}), 32'(t.cls));
    check({t.name, " zero"}, 32'(zero), 32'(t.res == 32'd0));
    @(posedge clk);
    #1;
    check({t.name, " result_q"}, result_q, t.res);
    check({t.name, " branch_q"}, 32'(branch_q), 32'(t.br));
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = v("sub",        mk(6'h00, 5'd0, 6'h22), 32'd2, 32'd3, 32'hFFFF_FFFF, 1'b0, C_R);
    vecs[1]  = v("bgt_taken",  mk(6'h07, 5'd0, 6'h00), 32'd3, 32'd1, 32'd2, 1'b1, C_I);
    vecs[2]  = v("ble_not",    mk(6'h06, 5'd0, 6'h00), 32'd4, 32'd2, 32'd2, 1'b0, C_I);
    vecs[3]  = v("ble_signed", mk(6'h06, 5'd0, 6'h00), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, C_I);
    vecs[4]  = v("lw",         mk(6'h23, 5'd0, 6'h01), 32'd0, 32'd1, 32'd1, 1'b0, C_I);
    vecs[5]  = v("beq_zero",   mk(6'h04, 5'd0, 6'h00), 32'd0, 32'd0, 32'd0, 1'b1, C_I);
    vecs[6]  = v("j",          mk(6'h3F, 5'd0, 6'h20), 32'd9, 32'd7, 32'd0, 1'b0, C_J);
    vecs[7]  = v("op_010101",  mk(6'h15, 5'd0, 6'h20), 32'd9, 32'd7, 32'd0, 1'b0, C_N);
    vecs[8]  = v("slt_neg",    mk(6'h00, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, C_R);
    vecs[9]  = v("nor",        mk(6'h00, 5'd0, 6'h27), 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, C_R);
    vecs[10] = v("bad_funct",  mk(6'h00, 5'd0, 6'h3F), 32'd5, 32'd6, 32'd0, 1'b0, C_R);
    vecs[11] = v("sll4",       mk(6'h00, 5'd4, 6'h00), 32'd0, 32'd1, SHIFT_ON ? 32'd16 : 32'd0, 1'b0, C_R);
    vecs[12] = v("bne_equal",  mk(6'h05, 5'd0, 6'h00), 32'd1, 32'd1, 32'd0, 1'b0, C_I);
    vecs[13] = v("jal",        mk(6'h3D, 5'd0, 6'h00), 32'd1, 32'd2, 32'd0, 1'b0, C_J);
    vecs[14] = v("add_wrap",   mk(6'h00, 5'd0, 6'h20), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, C_R);
    vecs[15] = v("srl0",       mk(6'h00, 5'd0, 6'h02), 32'd0, 32'h80, SHIFT_ON ? 32'h80 : 32'd0, 1'b0, C_R);
  end

  logic [5:0] op_pool[16];
  logic [5:0] fn_pool[12];

  initial begin
    logic [31:0] e_res;
    logic        e_br;
    logic [2:0]  e_cls;
    logic [31:0] ins;

    op_pool = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04,
                6'h05, 6'h06, 6'h07, 6'h3F, 6'h3E, 6'h3D, 6'h15, 6'h01};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
                6'h02, 6'h21, 6'h03, 6'h3F};

    rst_n = 1'b0;
    instr = mk(6'h08, 5'd0, 6'h00);
    op_a  = 32'd10;
    op_b  = 32'd20;

    // Reset holds the registers at zero across a clock edge.
    @(posedge clk);
    #1;
    check("reset result_q", result_q, 32'd0);
    check("reset branch_q", 32'(branch_q), 32'd0);
    check("reset comb result", result, 32'd30);

    @(negedge clk);
    rst_n = 1'b1;
    op_a  = 32'd2;
    op_b  = 32'd3;
    @(posedge clk);
    #1;
    check("first edge result_q", result_q, 32'd5);

    // Mid-cycle asynchronous reset clears the register immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset result_q", result_q, 32'd0);
    check("comb during reset", result, 32'd5);
    @(posedge clk);
    #1;
    check("held in reset", result_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd1;
    @(posedge clk);
    #1;
    check("post-reset capture", result_q, 32'd8);

    foreach (vecs[i]) apply_and_check(vecs[i]);

    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      op  = op_pool[$urandom_range(15)];
      if ($urandom_range(9) == 0) op = 6'($urandom);
      ins = {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             fn_pool[$urandom_range(11)]};
      @(negedge clk);
      instr = ins;
      op_a  = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      if (op == 6'h00 || (op >= 6'h04 && op <= 6'h07))
        op_b = ($urandom_range(3) == 0) ? op_a : $urandom;
      else
        op_b = {16'd0, ins[15:0]};
      model(ins, op_a, op_b, e_res, e_br, e_cls);
      #1;
      check("rand result", result, e_res);
      check("rand branch", 32'(branch), 32'(e_br));
      check("rand class", 32'({is_r, is_i, is_j}), 32'(e_cls));
      check("rand zero", 32'(zero), 32'(e_res == 32'd0));
      @(posedge clk);
      #1;
      check("rand result_q", result_q, e_res);
      check("rand branch_q", 32'(branch_q), 32'(e_br));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
